pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised next-generation program counter for the RISC CPU fetch stage.
- Holds the fetch address and advances it by a configurable step.
- Accepts a prioritised redirect: conditional branch, jump, call or return.
- Contains an internal circular return-address stack (RAS) so call/return need no register-file round trip. Output drives instruction-memory address directly.

Parameters:
- WIDTH, 32, address width in bits.
- STEP, 1, increment per sequential fetch (1 = word-addressed, 4 = byte-addressed).
- RESET_VEC, 0, value loaded into pc on reset.
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- stall  in  1  hold pc and RAS this cycle.
- br_taken  in  1  conditional branch resolved taken.
- br_target  in  WIDTH  branch destination.
- jump  in  1  unconditional jump to jmp_target.
- call  in  1  jump to jmp_target and push return address.
- ret  in  1  return: pop RAS top into pc.
- jmp_target  in  WIDTH  jump/call destination.
- clr_err  in  1  clear sticky error flags.
- pc  out  WIDTH  registered current fetch address.
- pc_plus  out  WIDTH  combinational pc+STEP.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_empty  out  1  ras_count==0.
- ras_full  out  1  ras_count==RAS_DEPTH.
- ras_ovf  out  1  sticky: push while full.
- ras_unf  out  1  sticky: pop while empty.

Behaviour:
- Reset (reset==0, async): pc=RESET_VEC, ras_count=0, top pointer=0, ras_ovf=0, ras_unf=0. RAS storage contents are don't-care. All other activity is ignored while reset is low; deassertion is sampled by the flop, and the first update is on the first rising edge with reset==1.
- All updates happen on the rising edge; pc is visible one cycle after the redirect is sampled (latency 1).
- pc_plus = (pc+STEP) mod 2^WIDTH, so wrap-around is silent. All adders are WIDTH-bit and carries are discarded.
- stall==1: pc, RAS and ras_count hold; redirect inputs are ignored, so the producer must hold them. Error flags still clear on clr_err.
- Next-pc priority, highest first:
  - (1) ret
  - (2) call
  - (3) jump
  - (4) br_taken
  - (5) sequential: pc <= pc_plus.
- ret only, RAS non-empty: pc <= top entry; pointer--, count--.
- ret only, RAS empty: pc <= pc_plus; RAS unchanged; ras_unf <= 1.
- call only, not full: entry[ptr] <= pc_plus; pointer++; count++; pc <= jmp_target.
- call only, full: oldest entry is overwritten (circular pointer wraps); count stays RAS_DEPTH; ras_ovf <= 1; pc <= jmp_target.
- call & ret together (coroutine swap):
  - Non-empty RAS: pc <= jmp_target; top entry is replaced by pc_plus; count unchanged; no flags.
  - Empty RAS: behaves as call only.
- jump / br_taken alone: pc <= respective target; RAS untouched.
- jump & br_taken together: jump wins.
- Pointer arithmetic is modulo RAS_DEPTH.
- Flags:
  - clr_err==1 clears both flags unless the same cycle sets one; set wins.
  - Flags never self-clear.
- No X on outputs after reset; the RAS read of an empty entry is never exposed.

Decomposition:
- Shared package cpu_pkg holds:
  - the redirect-priority encoding as an enum (PC_SEQ, PC_BR, PC_JMP, PC_CALL, PC_RET, PC_SWAP);
  - the default address width constant ADDR_W=32;
  - RESET_VEC default.
- One natural sub-module: pc_ras (circular LIFO with push/pop/swap, count and ovf/unf pulses). pc_unit owns the pc register, priority mux and sticky flags.

Test Plan:
- Sequential/wrap: WIDTH=8, STEP=4, RESET_VEC=8'hF8; release reset, 3 clocks -> pc = F8, FC, 00, 04; pc_plus tracks pc+4.
- Redirect priority: pc=10; assert br_taken (br_target=40) and jump (jmp_target=80) together -> next pc=80. Next cycle br_taken only -> 40. Then stall=1 with br_taken -> pc holds 40.
- Call/return nest: STEP=1, pc=5. Call to 20, advance to 22, call to 30, then ret, ret -> pc sequence 20, 21, 22, 30, 23, 6; ras_count 1, 1, 1, 2, 1, 0.
- Overflow/underflow: RAS_DEPTH=4; 5 calls -> ras_full=1, ras_ovf=1, count=4; 4 rets restore the last four return addresses; 5th ret -> pc=pc_plus, ras_unf=1. clr_err -> both flags 0.
- Swap: RAS top=50, count=1, pc=70; call&ret with jmp_target=90 -> pc=90, top=71, count=1. A following ret -> pc=71.
- Async reset mid-operation: count=3, pc=123; drive reset=0 between clock edges -> pc=RESET_VEC, count=0, flags=0 immediately, without waiting for a clock edge. Release -> sequential fetch from RESET_VEC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: default address width, reset vector and
// the encoding of the next-pc source selected by the redirect priority mux.
package cpu_pkg;

    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] RESET_VEC_DEF = '0;

    typedef enum logic [2:0] {
        PC_SEQ,
        PC_BR,
        PC_JMP,
        PC_CALL,
        PC_RET,
        PC_SWAP
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. ptr_q addresses the next free slot, so the
// top entry lives at ptr_q-1; a push while full silently overwrites the oldest.
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             swap_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] top_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             ovf_o,
    output logic             unf_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, top_idx, wr_idx;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en;

    assign top_idx = ptr_q - 1'b1;
    assign top_o   = mem_q[top_idx];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        ovf_o   = 1'b0;
        unf_o   = 1'b0;
        if (push_i) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + 1'b1;
            if (full_o) ovf_o = 1'b1;
            else        count_d = count_q + 1'b1;
        end else if (pop_i) begin
            if (empty_o) begin
                unf_o = 1'b1;
            end else begin
                ptr_d   = top_idx;
                count_d = count_q - 1'b1;
            end
        end else if (swap_i) begin
            // Caller only swaps a non-empty stack: replace top in place.
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wdata_i;
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with prioritised redirect (ret > call > jump > branch)
// and an internal return-address stack with sticky overflow/underflow flags.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH     = ADDR_W,
    parameter int               STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
    parameter int               RAS_DEPTH = 4,
    localparam int              CW        = $clog2(RAS_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             clr_err,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic [CW-1:0]    ras_count,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf
);

    logic [WIDTH-1:0] pc_q, pc_d, ras_top;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             ovf_set, unf_set;
    pc_sel_e          sel;

    assign pc      = pc_q;
    assign pc_plus = pc_q + WIDTH'(STEP);
    assign ras_ovf = ovf_q;
    assign ras_unf = unf_q;

    always_comb begin
        sel = PC_SEQ;
        if (ret && call)   sel = ras_empty ? PC_CALL : PC_SWAP;
        else if (ret)      sel = PC_RET;
        else if (call)     sel = PC_CALL;
        else if (jump)     sel = PC_JMP;
        else if (br_taken) sel = PC_BR;
    end

    always_comb begin
        pc_d = pc_plus;
        unique case (sel)
            PC_BR:                    pc_d = br_target;
            PC_JMP, PC_CALL, PC_SWAP: pc_d = jmp_target;
            PC_RET:                   pc_d = ras_empty ? pc_plus : ras_top;
            default:                  pc_d = pc_plus;
        endcase
        if (stall) pc_d = pc_q;
    end

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (!stall && sel == PC_CALL),
        .pop_i   (!stall && sel == PC_RET),
        .swap_i  (!stall && sel == PC_SWAP),
        .wdata_i (pc_plus),
        .top_o   (ras_top),
        .count_o (ras_count),
        .empty_o (ras_empty),
        .full_o  (ras_full),
        .ovf_o   (ovf_set),
        .unf_o   (unf_set)
    );

    // A flag being set in the same cycle as clr_err stays set.
    assign ovf_d = ovf_set | (ovf_q & ~clr_err);
    assign unf_d = unf_set | (unf_q & ~clr_err);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_VEC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a wrap-around instance (8-bit, step 4) and a
// main instance (16-bit, step 1) driven from a table of hand-computed vectors.
module tb_pc_unit;

    typedef struct {
        logic        s, b, j, c, r, cl;
        logic [15:0] bt, jt;
        logic [15:0] e_pc;
        logic [2:0]  e_cnt;
        logic        e_ovf, e_unf;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        reset, stall, br_taken, jump, call, ret, clr_err;
    logic [15:0] br_target, jmp_target;
    logic [15:0] pc, pc_plus;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, ras_ovf, ras_unf;

    // wrap instance
    logic        rst_w, zero_b;
    logic [7:0]  zero_w, w_pc, w_pc_plus;
    logic [2:0]  w_count;
    logic        w_empty, w_full, w_ovf, w_unf;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    logic [7:0] exp_q[$];

    pc_unit #(.WIDTH(16), .STEP(1), .RESET_VEC(16'h0000), .RAS_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .jump(jump), .call(call), .ret(ret),
        .jmp_target(jmp_target), .clr_err(clr_err), .pc(pc), .pc_plus(pc_plus),
        .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    pc_unit #(.WIDTH(8), .STEP(4), .RESET_VEC(8'hF8), .RAS_DEPTH(4)) dut_w (
        .clk(clk), .reset(rst_w), .stall(zero_b), .br_taken(zero_b),
        .br_target(zero_w), .jump(zero_b), .call(zero_b), .ret(zero_b),
        .jmp_target(zero_w), .clr_err(zero_b), .pc(w_pc), .pc_plus(w_pc_plus),
        .ras_count(w_count), .ras_empty(w_empty), .ras_full(w_full),
        .ras_ovf(w_ovf), .ras_unf(w_unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(input logic s, b, j, c, r, cl,
                               input logic [15:0] bt, jt, epc,
                               input int cnt, input logic eo, eu);
        vec_t x;
        x.s = s; x.b = b; x.j = j; x.c = c; x.r = r; x.cl = cl;
        x.bt = bt; x.jt = jt; x.e_pc = epc; x.e_cnt = 3'(cnt);
        x.e_ovf = eo; x.e_unf = eu;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        stall = x.s; br_taken = x.b; jump = x.j; call = x.c; ret = x.r;
        clr_err = x.cl; br_target = x.bt; jmp_target = x.jt;
    endtask

    task automatic check_main(input string tag, input logic [15:0] epc, input logic [2:0] ecnt,
                              input logic eo, input logic eu);
        logic [15:0] epp;
        epp = epc + 16'd1;
        chk({tag, ".pc"}, 32'(pc), 32'(epc));
        chk({tag, ".pc_plus"}, 32'(pc_plus), 32'(epp));
        chk({tag, ".count"}, 32'(ras_count), 32'(ecnt));
        chk({tag, ".empty"}, 32'(ras_empty), 32'(ecnt == 3'd0));
        chk({tag, ".full"}, 32'(ras_full), 32'(ecnt == 3'd4));
        chk({tag, ".ovf"}, 32'(ras_ovf), 32'(eo));
        chk({tag, ".unf"}, 32'(ras_unf), 32'(eu));
    endtask

    initial begin
        reset = 1'b0; rst_w = 1'b0; zero_b = 1'b0; zero_w = '0;
        drive(v(0,0,0,0,0,0, 16'h0, 16'h0, 16'h0, 0, 0, 0));

        // redirect priority and stall
        tbl.push_back(v(0,0,1,0,0,0, 16'h0,   16'h10,  16'h10,  0, 0, 0));
        tbl.push_back(v(0,1,1,0,0,0, 16'h40,  16'h80,  16'h80,  0, 0, 0));
        tbl.push_back(v(0,1,0,0,0,0, 16'h40,  16'h0,   16'h40,  0, 0, 0));
        tbl.push_back(v(1,1,0,0,0,0, 16'h55,  16'h0,   16'h40,  0, 0, 0));
        tbl.push_back(v(1,0,0,0,0,0, 16'h0,   16'h0,   16'h40,  0, 0, 0));
        tbl.push_back(v(0,0,0,0,0,0, 16'h0,   16'h0,   16'h41,  0, 0, 0));
        // call/return nest
        tbl.push_back(v(0,0,1,0,0,0, 16'h0,   16'h5,   16'h5,   0, 0, 0));
        tbl.push_back(v(0,0,0,1,0,0, 16'h0,   16'h20,  16'h20,  1, 0, 0));
        tbl.push_back(v(0,0,0,0,0,0, 16'h0,   16'h0,   16'h21,  1, 0, 0));
        tbl.push_back(v(0,0,0,0,0,0, 16'h0,   16'h0,   16'h22,  1, 0, 0));
        tbl.push_back(v(0,0,0,1,0,0, 16'h0,   16'h30,  16'h30,  2, 0, 0));
        tbl.push_back(v(0,0,0,0,1,0, 16'h0,   16'h0,   16'h23,  1, 0, 0));
        tbl.push_back(v(0,0,0,0,1,0, 16'h0,   16'h0,   16'h6,   0, 0, 0));
        // overflow then underflow
        tbl.push_back(v(0,0,0,1,0,0, 16'h0,   16'h100, 16'h100, 1, 0, 0));
        tbl.push_back(v(0,0,0,1,0,0, 16'h0,   16'h200, 16'h200, 2, 0, 0));
        tbl.push_back(v(0,0,0,1,0,0, 16'h0,   16'h300, 16'h300, 3, 0, 0));
        tbl.push_back(v(0,0,0,1,0,0, 16'h0,   16'h400, 16'h400, 4, 0, 0));
        tbl.push_back(v(0,0,0,1,0,0, 16'h0,   16'h500, 16'h500, 4, 1, 0));
        tbl.push_back(v(1,0,0,1,0,0, 16'h0,   16'h600, 16'h500, 4, 1, 0));
        tbl.push_back(v(0,0,0,0,1,0, 16'h0,   16'h0,   16'h401, 3, 1, 0));
        tbl.push_back(v(0,0,0,0,1,0, 16'h0,   16'h0,   16'h301, 2, 1, 0));
        tbl.push_back(v(0,0,0,0,1,0, 16'h0,   16'h0,   16'h201, 1, 1, 0));
        tbl.push_back(v(0,0,0,0,1,0, 16'h0,   16'h0,   16'h101, 0, 1, 0));
        tbl.push_back(v(0,0,0,0,1,0, 16'h0,   16'h0,   16'h102, 0, 1, 1));
        tbl.push_back(v(0,0,0,0,0,1, 16'h0,   16'h0,   16'h103, 0, 0, 0));
        tbl.push_back(v(0,0,0,0,1,1, 16'h0,   16'h0,   16'h104, 0, 0, 1));
        tbl.push_back(v(1,0,0,0,0,1, 16'h0,   16'h0,   16'h104, 0, 0, 0));
        // coroutine swap, then swap on empty stack behaving as call
        tbl.push_back(v(0,0,1,0,0,0, 16'h0,   16'h4F,  16'h4F,  0, 0, 0));
        tbl.push_back(v(0,0,0,1,0,0, 16'h0,   16'h70,  16'h70,  1, 0, 0));
        tbl.push_back(v(0,0,0,1,1,0, 16'h0,   16'h90,  16'h90,  1, 0, 0));
        tbl.push_back(v(0,0,0,0,1,0, 16'h0,   16'h0,   16'h71,  0, 0, 0));
        tbl.push_back(v(0,0,0,1,1,0, 16'h0,   16'hA0,  16'hA0,  1, 0, 0));
        tbl.push_back(v(0,0,0,0,1,0, 16'h0,   16'h0,   16'h72,  0, 0, 0));
        // ret outranks jump and branch
        tbl.push_back(v(0,0,0,1,0,0, 16'h0,   16'hC0,  16'hC0,  1, 0, 0));
        tbl.push_back(v(0,1,1,0,1,0, 16'hF0,  16'hE0,  16'h73,  0, 0, 0));
        // 16-bit wrap
        tbl.push_back(v(0,0,1,0,0,0, 16'h0,   16'hFFFF, 16'hFFFF, 0, 0, 0));
        tbl.push_back(v(0,0,0,0,0,0, 16'h0,   16'h0,   16'h0,   0, 0, 0));
        // build state for the async reset test: unf set, count 3, pc 123
        tbl.push_back(v(0,0,0,0,1,0, 16'h0,   16'h0,   16'h1,   0, 0, 1));
        tbl.push_back(v(0,0,1,0,0,0, 16'h0,   16'h10,  16'h10,  0, 0, 1));
        tbl.push_back(v(0,0,0,1,0,0, 16'h0,   16'h100, 16'h100, 1, 0, 1));
        tbl.push_back(v(0,0,0,1,0,0, 16'h0,   16'h110, 16'h110, 2, 0, 1));
        tbl.push_back(v(0,0,0,1,0,0, 16'h0,   16'h123, 16'h123, 3, 0, 1));

        repeat (2) @(posedge clk);
        #1;
        check_main("reset", 16'h0, 3'd0, 1'b0, 1'b0);
        chk("w_reset.pc", 32'(w_pc), 32'h F8);
        chk("w_reset.count", 32'(w_count), 32'd0);

        // release both; wrap instance counts F8, FC, 00, 04
        reset = 1'b1; rst_w = 1'b1;
        exp_q.push_back(8'hF8); exp_q.push_back(8'hFC);
        exp_q.push_back(8'h00); exp_q.push_back(8'h04);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e, ep;
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            e  = exp_q.pop_front();
            ep = e + 8'd4;
            chk("wrap.pc", 32'(w_pc), 32'(e));
            chk("wrap.pc_plus", 32'(w_pc_plus), 32'(ep));
            check_main("seq", 16'(i), 3'd0, 1'b0, 1'b0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check_main($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_cnt, tbl[i].e_ovf, tbl[i].e_unf);
        end
        drive(v(0,0,0,0,0,0, 16'h0, 16'h0, 16'h0, 0, 0, 0));

        // asynchronous reset between edges takes effect immediately
        #2 reset = 1'b0;
        #1 check_main("async_rst", 16'h0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_main("rst_hold", 16'h0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 check_main("post_rst1", 16'h1, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_main("post_rst2", 16'h2, 3'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
